imem_loader: RTL and testbench

Boot-time writer for the instruction memory: accepts a length-prefixed byte stream over a valid/ready interface, assembles big-endian 32-bit instruction words and writes them to consecutive IM word addresses. The CPU fetches from IM; this block fills it. It sits beside `mips` in the top level and holds the processor in reset (`cpu_hold`) until the image is fully loaded.

---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 169 ++++++++++++++++
 tb/tb_imem_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream and instruction-memory write bus of the loader.
//   byte_valid/byte_data/byte_ready : valid/ready byte stream (source -> loader)
//   im_we/im_addr/im_wdata          : IM word write port (loader -> IM)
// Modports: slave = loader side, master = stream source / IM side.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Takes a stream LEN_HI, LEN_LO (word count N, big-endian) followed by 4*N bytes,
// packs each 4 bytes big-endian into a 32-bit word and writes consecutive IM
// words starting at 0. Holds the CPU in reset until the image is complete.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   start    : pulse, begins a load from IDLE/DONE/ERR
//   bus      : byte stream in, IM write port out (imem_loader_if.slave)
//   cpu_hold : 1 keeps the CPU in reset
//   done     : image loaded (level until next start)
//   err      : declared length exceeds IM capacity (level until next start)
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_loader_if.slave        bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE,
    S_ERR
  } state_e;

  // Capacity in words; 33 bits so the compare against a 16-bit N never overflows.
  localparam logic [32:0] CAP = 33'd1 << ADDR_W;

  state_e            state_q, state_d;
  // One bit wider than im_addr so that N = 2^ADDR_W is representable.
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        bcnt_q, bcnt_d;
  // First three bytes of the word in flight; the fourth comes straight from the bus.
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;

  logic              byte_ready;
  logic              xfer;
  logic [15:0]       len_n;

  assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA);
  assign xfer       = bus.byte_valid && byte_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;
    len_n   = {len_q[15:8], bus.byte_data};

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          done_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          bcnt_d  = '0;
          hold_d  = 1'b1;
        end
      end

      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = bus.byte_data;
          state_d     = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_n;
          if (len_n == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else if ({17'd0, len_n} > CAP) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = idx_q[ADDR_W-1:0];
            wdata_d = {asm_q, bus.byte_data};
            idx_d   = idx_q + 1'b1;
            // Last word: finish on the same edge as the write so done and
            // the CPU release coincide with the final im_we cycle.
            if (32'(idx_q) + 32'd1 == 32'(len_q)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
            end
          end else begin
            asm_d = {asm_q[15:0], bus.byte_data};
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.im_we      = we_q;
  assign bus.im_addr    = addr_q;
  assign bus.im_wdata   = wdata_q;
  assign cpu_hold       = hold_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (ADDR_W = 4, 16-word IM).
// Stimulus pushes the expected {addr, data, last} of every word it sends;
// a negedge monitor pops and compares on every im_we cycle.
module tb_imem_loader;
  localparam int AW = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          last;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done, err;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus.slave),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int we_cnt = 0;
  int last_addr = -1;
  wr_t sb[$];
  int wcyc[$];
  logic [31:0] mem [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every im_we cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      wr_t e;
      we_cnt++;
      last_addr = int'(bus.im_addr);
      wcyc.push_back(cyc);
      mem[bus.im_addr] = bus.im_wdata;
      if (sb.size() == 0) begin
        chk("unexpected_we", 32'(bus.im_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("we_addr", 32'(bus.im_addr), 32'(e.addr));
        chk("we_data", bus.im_wdata, e.data);
        chk("we_done", 32'(done), 32'(e.last));
        chk("we_hold", 32'(cpu_hold), 32'(!e.last));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.byte_valid = 1'b0;
    tick(gap);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    @(negedge clk);
    while (!bus.byte_ready && n < 50) begin n++; @(negedge clk); end
    chk("byte_accept", 32'(bus.byte_ready), 32'd1);
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[15:8], 0);
    send_byte(n[7:0], 0);
  endtask

  // start_at: byte index (0..3) during which start is also asserted, -1 for none.
  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic last, input int gaps[4], input int start_at);
    wr_t e;
    e.addr = a; e.data = d; e.last = last;
    sb.push_back(e);
    for (int i = 0; i < 4; i++) begin
      if (i == start_at) start = 1'b1;
      send_byte(d[31-8*i -: 8], gaps[i]);
      start = 1'b0;
    end
  endtask

  task automatic check_finished(input string tag);
    tick(2);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_pending"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_we"}, 32'(bus.im_we), 32'd0);
    chk({tag, "_addr"}, 32'(bus.im_addr), 32'd0);
    chk({tag, "_wdata"}, bus.im_wdata, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
  endtask

  initial begin
    int z[4];
    int g0[4];
    int g1[4];
    int w0;
    z = '{0, 0, 0, 0};
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset values
    tick(2);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst = 1'b1;
    tick(2);

    // Two words, no gaps
    pulse_start();
    wcyc.delete();
    send_len(16'd2);
    send_word(4'd0, 32'h12345678, 1'b0, z, -1);
    send_word(4'd1, 32'h9ABCDEF0, 1'b1, z, -1);
    check_finished("t1");
    chk("t1_we_count", 32'(wcyc.size()), 32'd2);
    if (wcyc.size() == 2) chk("t1_spacing", 32'(wcyc[1] - wcyc[0]), 32'd4);
    chk("t1_mem0", mem[0], 32'h12345678);
    chk("t1_mem1", mem[1], 32'h9ABCDEF0);

    // Same image with stalls, including mid-word
    mem[0] = '0; mem[1] = '0;
    w0 = we_cnt;
    g0 = '{1, 0, 2, 3};
    g1 = '{0, 2, 1, 1};
    pulse_start();
    send_byte(8'h00, 2);
    send_byte(8'h02, 1);
    send_word(4'd0, 32'h12345678, 1'b0, g0, -1);
    send_word(4'd1, 32'h9ABCDEF0, 1'b1, g1, -1);
    check_finished("t2");
    chk("t2_we_count", 32'(we_cnt - w0), 32'd2);
    chk("t2_mem0", mem[0], 32'h12345678);
    chk("t2_mem1", mem[1], 32'h9ABCDEF0);

    // N = 0: done on the LEN_LO edge, no writes
    w0 = we_cnt;
    pulse_start();
    chk("t3_done_cleared", 32'(done), 32'd0);
    send_len(16'd0);
    @(negedge clk);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_hold", 32'(cpu_hold), 32'd0);
    tick(3);
    chk("t3_no_we", 32'(we_cnt - w0), 32'd0);

    // N = 16 = full capacity
    pulse_start();
    send_len(16'd16);
    for (int k = 0; k < 16; k++)
      send_word(4'(k), 32'h1000_0000 + 32'(k) * 32'h0101_0101, k == 15, z, -1);
    check_finished("t4");
    chk("t4_last_addr", 32'(last_addr), 32'd15);
    chk("t4_mem15", mem[15], 32'h1F0F_0F0F);

    // N = 17 -> ERR, stream not consumed
    w0 = we_cnt;
    pulse_start();
    send_len(16'd17);
    @(negedge clk);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_ready", 32'(bus.byte_ready), 32'd0);
    chk("t5_hold", 32'(cpu_hold), 32'd1);
    chk("t5_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    tick(5);
    bus.byte_valid = 1'b0;
    chk("t5_no_we", 32'(we_cnt - w0), 32'd0);
    chk("t5_err_held", 32'(err), 32'd1);

    // Reset after 6 data bytes, then a fresh load
    pulse_start();
    chk("t6_err_cleared", 32'(err), 32'd0);
    send_len(16'd2);
    send_word(4'd0, 32'hCAFEF00D, 1'b0, z, -1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("t6_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    tick(1);
    pulse_start();
    send_len(16'd1);
    send_word(4'd0, 32'hDEADBEEF, 1'b1, z, -1);
    check_finished("t6");
    chk("t6_mem0", mem[0], 32'hDEADBEEF);

    // start during DATA is ignored
    pulse_start();
    send_len(16'd2);
    send_word(4'd0, 32'h01020304, 1'b0, z, 1);
    send_word(4'd1, 32'h05060708, 1'b1, z, 2);
    check_finished("t7");
    chk("t7_mem0", mem[0], 32'h01020304);
    chk("t7_mem1", mem[1], 32'h05060708);

    // start in DONE with a byte offered the same cycle: byte is not consumed
    start = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h07;
    tick(1);
    start = 1'b0;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    chk("t8_done_cleared", 32'(done), 32'd0);
    chk("t8_hold", 32'(cpu_hold), 32'd1);
    chk("t8_ready", 32'(bus.byte_ready), 32'd1);
    @(posedge clk); #1;
    send_len(16'd1);
    send_word(4'd0, 32'hA5A55A5A, 1'b1, z, -1);
    check_finished("t8");
    chk("t8_mem0", mem[0], 32'hA5A55A5A);
    chk("t8_mem1", mem[1], 32'h05060708);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
